// File: rtl/led_pattern_sequencer.sv
// Purpose: steps one of four LED patterns (walk-left, walk-right, count, ping-pong) per divider enable pulse.
// Latency: all outputs registered; leds change 1 cycle after the en pulse that steps them.
// Backpressure: mode_ready drops while a RUN-time mode change waits for the next en to apply it.
// Optional: define LED_AUTOSTOP_EN to add the max_steps input and the done autostop pulse.
module led_pattern_sequencer #(
    parameter int LED_W  = 8,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [1:0]        mode,
    input  logic              mode_valid,
    output logic              mode_ready,
`ifdef LED_AUTOSTOP_EN
    input  logic [STEP_W-1:0] max_steps,
`endif
    output logic [LED_W-1:0]  leds,
    output logic              busy,
    output logic [STEP_W-1:0] step_count,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    state_t            state_q, state_n;
    logic [LED_W-1:0]  leds_q, leds_n, step_leds;
    logic [STEP_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic [1:0]        act_q, act_n, pmode_q, pmode_n;
    logic              pend_q, pend_n;
    logic              reseed_q, reseed_n;
    logic              dir_q, dir_n, step_dir;
    logic              done_q, done_n;
    logic              busy_q;
    logic              accept;
    logic              term_hit;

    // Starting LED image for each pattern
    function automatic logic [LED_W-1:0] seed(input logic [1:0] m);
        logic [LED_W-1:0] s;
        s = '0;
        if (m == 2'd1)
            s[LED_W-1] = 1'b1;
        else if (m != 2'd2)
            s[0] = 1'b1;
        return s;
    endfunction

    assign accept  = mode_valid && !pend_q;
    assign cnt_inc = cnt_q + STEP_W'(1);

`ifdef LED_AUTOSTOP_EN
    // Terminal step: a real pattern step (not a seed load) that lands on max_steps
    assign term_hit = (state_q == S_RUN) && en && !pause && !pend_q && !reseed_q && !done_q
                      && (max_steps != '0) && (cnt_inc == max_steps);
`else
    assign term_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_n;
    end

    // Next-state: stop beats pause beats start; a done pulse retires RUN like a stop
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: if (start && !stop) state_n = S_LOAD;
            S_LOAD: begin
                if (stop)       state_n = S_IDLE;
                else if (pause) state_n = S_HOLD;
                else            state_n = S_RUN;
            end
            S_RUN: begin
                if (stop || done_q) state_n = S_IDLE;
                else if (pause)     state_n = S_HOLD;
            end
            S_HOLD: begin
                if (stop)                 state_n = S_IDLE;
                else if (start && !pause) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One pattern step from the current LEDs and ping-pong direction
    always_comb begin
        step_leds = leds_q;
        step_dir  = dir_q;
        case (act_q)
            2'd0: step_leds = {leds_q[LED_W-2:0], leds_q[LED_W-1]};
            2'd1: step_leds = {leds_q[0], leds_q[LED_W-1:1]};
            2'd2: step_leds = leds_q + LED_W'(1);
            default: begin
                if (dir_q == DIR_LEFT) begin
                    step_leds = leds_q << 1;
                    if (step_leds[LED_W-1]) step_dir = DIR_RIGHT;
                end else begin
                    step_leds = leds_q >> 1;
                    if (step_leds[0]) step_dir = DIR_LEFT;
                end
            end
        endcase
    end

    // Output/datapath next values: seed loads, steps, and the mode handshake
    always_comb begin
        leds_n   = leds_q;
        cnt_n    = cnt_q;
        act_n    = act_q;
        pmode_n  = pmode_q;
        pend_n   = pend_q;
        reseed_n = reseed_q;
        dir_n    = dir_q;
        done_n   = term_hit;
        if (state_q == S_IDLE) begin
            leds_n = '0;
            if (accept) act_n = mode;
        end else if (stop || (state_q == S_RUN && done_q)) begin
            // Leaving for IDLE: an accepted or waiting request still becomes the active mode
            leds_n   = '0;
            pend_n   = 1'b0;
            reseed_n = 1'b0;
            if (accept)      act_n = mode;
            else if (pend_q) act_n = pmode_q;
        end else if (state_q == S_HOLD) begin
            // Mode switches at once; the new seed is shown on the first RUN cycle
            if (accept) begin
                act_n    = mode;
                reseed_n = 1'b1;
            end
        end else begin
            if (state_q == S_LOAD || (!pause && reseed_q)) begin
                leds_n   = seed(act_q);
                cnt_n    = '0;
                dir_n    = DIR_LEFT;
                reseed_n = 1'b0;
            end else if (!pause && en) begin
                if (pend_q) begin
                    act_n  = pmode_q;
                    leds_n = seed(pmode_q);
                    cnt_n  = '0;
                    dir_n  = DIR_LEFT;
                    pend_n = 1'b0;
                end else begin
                    leds_n = step_leds;
                    dir_n  = step_dir;
                    cnt_n  = cnt_inc;
                end
            end
            if (accept) begin
                pend_n  = 1'b1;
                pmode_n = mode;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q   <= '0;
            cnt_q    <= '0;
            act_q    <= 2'd0;
            pmode_q  <= 2'd0;
            pend_q   <= 1'b0;
            reseed_q <= 1'b0;
            dir_q    <= DIR_LEFT;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            leds_q   <= leds_n;
            cnt_q    <= cnt_n;
            act_q    <= act_n;
            pmode_q  <= pmode_n;
            pend_q   <= pend_n;
            reseed_q <= reseed_n;
            dir_q    <= dir_n;
            done_q   <= done_n;
            busy_q   <= (state_n != S_IDLE);
        end
    end

    assign leds       = leds_q;
    assign busy       = busy_q;
    assign step_count = cnt_q;
    assign done       = done_q;
    assign mode_ready = !pend_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus a randomized run against a pattern model.
// The model tracks pattern mode and step index; LED images are computed arithmetically from those.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_led_pattern_sequencer;
    localparam int LED_W  = 8;
    localparam int STEP_W = 16;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HOLD = 3;

    logic              clk = 1'b0;
    logic              rst, en, start, stop, pause, mode_valid;
    logic [1:0]        mode;
    logic              mode_ready, busy, done;
    logic [LED_W-1:0]  leds;
    logic [STEP_W-1:0] step_count;
`ifdef LED_AUTOSTOP_EN
    logic [STEP_W-1:0] max_steps = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int m_st, m_act, m_pend, m_pmode, m_reseed, m_on, m_smode, m_k, m_cnt;

    led_pattern_sequencer #(.LED_W(LED_W), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .mode_valid(mode_valid), .mode_ready(mode_ready),
`ifdef LED_AUTOSTOP_EN
        .max_steps(max_steps),
`endif
        .leds(leds), .busy(busy), .step_count(step_count), .done(done)
    );

    always #5 clk = ~clk;

    // LED image after kk steps from the seed of pattern md
    function automatic logic [7:0] pat(input int md, input int kk);
        logic [7:0] r;
        int t;
        r = 8'h00;
        case (md)
            0: r[kk % 8] = 1'b1;
            1: r[7 - (kk % 8)] = 1'b1;
            2: r = 8'(kk % 256);
            default: begin
                t = kk % 14;
                r[(t < 8) ? t : 14 - t] = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_act = 0; m_pend = 0; m_pmode = 0; m_reseed = 0;
        m_on = 0; m_smode = 0; m_k = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = mode_valid && (m_pend == 0);
        if (m_st == M_IDLE) begin
            if (acc) m_act = int'(mode);
            if (start && !stop) m_st = M_LOAD;
        end else if (stop) begin
            if (acc) m_act = int'(mode);
            else if (m_pend != 0) m_act = m_pmode;
            m_pend = 0; m_reseed = 0; m_on = 0; m_st = M_IDLE;
        end else if (m_st == M_HOLD) begin
            if (acc) begin m_act = int'(mode); m_reseed = 1; end
            if (start && !pause) m_st = M_RUN;
        end else begin
            if (m_st == M_LOAD) begin
                m_smode = m_act; m_k = 0; m_cnt = 0; m_on = 1;
            end else if (!pause && m_reseed != 0) begin
                m_smode = m_act; m_k = 0; m_cnt = 0; m_reseed = 0;
            end else if (!pause && en) begin
                if (m_pend != 0) begin
                    m_act = m_pmode; m_smode = m_pmode; m_k = 0; m_cnt = 0; m_pend = 0;
                end else begin
                    m_k = m_k + 1; m_cnt = (m_cnt + 1) % 65536;
                end
            end
            if (acc) begin m_pend = 1; m_pmode = int'(mode); end
            m_st = pause ? M_HOLD : M_RUN;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode_valid = 1'b0; mode = 2'd0;
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] m);
        mode = m; mode_valid = 1'b1; tick(); mode_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        start_run(2'd2);
        en = 1'b1; tick(); en = 1'b0; tick();
        #2 rst = 1'b1; model_reset();
        #1;
        n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL reset_leds: got %h want 00", leds); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (step_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", step_count); end
        n_cmp++; if (mode_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", mode_ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        #2 rst = 1'b0;
    endtask

    task automatic test_walk_left();
        logic [7:0] exp;
        do_reset();
        start_run(2'd0);
        n_cmp++; if (leds !== 8'h01) begin n_bad++; $display("FAIL wl_seed: got %h want 01", leds); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wl_busy: got %b want 1", busy); end
        for (int i = 1; i <= 9; i++) begin
            en = 1'b1; tick(); en = 1'b0;
            exp = 8'h01 << (i % 8);
            n_cmp++; if (leds !== exp) begin n_bad++; $display("FAIL wl_step%0d: got %h want %h", i, leds, exp); end
            tick();
        end
        n_cmp++; if (step_count !== 16'd9) begin n_bad++; $display("FAIL wl_count: got %0d want 9", step_count); end
    endtask

    task automatic test_pingpong();
        int t;
        logic [7:0] exp;
        do_reset();
        start_run(2'd3);
        for (int i = 1; i <= 16; i++) begin
            en = 1'b1; tick(); en = 1'b0;
            t = i % 14;
            exp = 8'h01 << ((t < 8) ? t : 14 - t);
            n_cmp++; if (leds !== exp) begin n_bad++; $display("FAIL pp_step%0d: got %h want %h", i, leds, exp); end
        end
        n_cmp++; if (step_count !== 16'd16) begin n_bad++; $display("FAIL pp_count: got %0d want 16", step_count); end
    endtask

    task automatic test_mode_change();
        do_reset();
        start_run(2'd2);
        for (int i = 0; i < 5; i++) begin en = 1'b1; tick(); en = 1'b0; tick(); end
        n_cmp++; if (leds !== 8'h05) begin n_bad++; $display("FAIL mc_pre: got %h want 05", leds); end
        mode = 2'd1; mode_valid = 1'b1; tick(); mode_valid = 1'b0; tick();
        n_cmp++; if (mode_ready !== 1'b0) begin n_bad++; $display("FAIL mc_ready_low: got %b want 0", mode_ready); end
        n_cmp++; if (leds !== 8'h05) begin n_bad++; $display("FAIL mc_wait: got %h want 05", leds); end
        en = 1'b1; tick(); en = 1'b0;
        n_cmp++; if (leds !== 8'h80) begin n_bad++; $display("FAIL mc_seed: got %h want 80", leds); end
        n_cmp++; if (step_count !== 16'd0) begin n_bad++; $display("FAIL mc_count: got %0d want 0", step_count); end
        n_cmp++; if (mode_ready !== 1'b1) begin n_bad++; $display("FAIL mc_ready_high: got %b want 1", mode_ready); end
        en = 1'b1; tick(); en = 1'b0;
        n_cmp++; if (leds !== 8'h40) begin n_bad++; $display("FAIL mc_step: got %h want 40", leds); end
    endtask

    task automatic test_pause_hold();
        do_reset();
        start_run(2'd0);
        for (int i = 0; i < 2; i++) begin en = 1'b1; tick(); en = 1'b0; tick(); end
        en = 1'b1; pause = 1'b1; tick(); en = 1'b0; pause = 1'b0;
        n_cmp++; if (leds !== 8'h04) begin n_bad++; $display("FAIL ph_pause_en: got %h want 04", leds); end
        for (int i = 0; i < 3; i++) begin
            tick(); en = 1'b1; tick(); en = 1'b0;
            n_cmp++; if (leds !== 8'h04) begin n_bad++; $display("FAIL ph_hold%0d: got %h want 04", i, leds); end
        end
        n_cmp++; if (step_count !== 16'd2) begin n_bad++; $display("FAIL ph_count: got %0d want 2", step_count); end
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; tick(); en = 1'b0;
        n_cmp++; if (leds !== 8'h08) begin n_bad++; $display("FAIL ph_resume: got %h want 08", leds); end
        n_cmp++; if (step_count !== 16'd3) begin n_bad++; $display("FAIL ph_resume_count: got %0d want 3", step_count); end
    endtask

    task automatic test_stop_reset();
        do_reset();
        start_run(2'd0);
        for (int i = 0; i < 2; i++) begin en = 1'b1; tick(); en = 1'b0; tick(); end
        en = 1'b1; stop = 1'b1; tick(); en = 1'b0; stop = 1'b0;
        n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL st_leds: got %h want 00", leds); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL st_busy: got %b want 0", busy); end
        start_run(2'd0);
        en = 1'b1; tick(); en = 1'b0;
        mode = 2'd1; mode_valid = 1'b1; tick(); mode_valid = 1'b0;
        n_cmp++; if (mode_ready !== 1'b0) begin n_bad++; $display("FAIL st_pending: got %b want 0", mode_ready); end
        #2 rst = 1'b1; model_reset();
        #1;
        n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL ar_leds: got %h want 00", leds); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b want 0", busy); end
        n_cmp++; if (mode_ready !== 1'b1) begin n_bad++; $display("FAIL ar_ready: got %b want 1", mode_ready); end
        #2 rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick();
        n_cmp++; if (leds !== 8'h01) begin n_bad++; $display("FAIL ar_seed: got %h want 01", leds); end
        en = 1'b1; tick(); en = 1'b0;
        n_cmp++; if (leds !== 8'h02) begin n_bad++; $display("FAIL ar_step: got %h want 02", leds); end
    endtask

    task automatic test_random();
        logic [7:0] el;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en         = ($urandom_range(0, 3) == 0);
            start      = ($urandom_range(0, 5) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            pause      = ($urandom_range(0, 11) == 0);
            mode_valid = ($urandom_range(0, 7) == 0);
            mode       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1; model_reset();
                #2 rst = 1'b0;
            end
            tick();
            el = (m_on != 0) ? pat(m_smode, m_k) : 8'h00;
            n_cmp++; if (leds !== el) begin n_bad++; $display("FAIL rnd_leds c=%0d: got %h want %h", c, leds, el); end
            n_cmp++; if (busy !== (m_st != M_IDLE)) begin n_bad++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_st != M_IDLE); end
            n_cmp++; if (step_count !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, step_count, m_cnt); end
            n_cmp++; if (mode_ready !== (m_pend == 0)) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, mode_ready, m_pend == 0); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rnd_done c=%0d: got %b want 0", c, done); end
        end
        en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode_valid = 1'b0;
    endtask

`ifdef LED_AUTOSTOP_EN
    task automatic test_autostop();
        do_reset();
        max_steps = 16'd4;
        start_run(2'd0);
        for (int i = 1; i <= 4; i++) begin
            en = 1'b1; tick(); en = 1'b0;
            n_cmp++; if (done !== (i == 4)) begin n_bad++; $display("FAIL as_done%0d: got %b want %b", i, done, i == 4); end
            if (i < 4) tick();
        end
        n_cmp++; if (step_count !== 16'd4) begin n_bad++; $display("FAIL as_count: got %0d want 4", step_count); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL as_done_clear: got %b want 0", done); end
        n_cmp++; if (leds !== 8'h00) begin n_bad++; $display("FAIL as_leds: got %h want 00", leds); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL as_busy: got %b want 0", busy); end
        do_reset();
        max_steps = 16'd2;
        start_run(2'd0);
        en = 1'b1; tick(); en = 1'b0; tick();
        en = 1'b1; stop = 1'b1; tick(); en = 1'b0; stop = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL as_stop_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL as_stop_busy: got %b want 0", busy); end
        max_steps = '0;
        do_reset();
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode_valid = 1'b0; mode = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_walk_left();
        test_pingpong();
        test_mode_change();
        test_pause_hold();
        test_stop_reset();
        test_random();
`ifdef LED_AUTOSTOP_EN
        test_autostop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
